// File: rtl/mips_mem_pkg.sv
// Shared types for the unified memory port arbiter.
// FSM state and grant encodings plus the wait counter width.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } arb_gnt_t;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/arb_perf_counter.sv
// Saturating 32-bit event counter.
// Ports: clk, reset (sync, high), inc (count enable), count (value).
module arb_perf_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && count != 32'hFFFF_FFFF)
      count <= count + 32'd1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and data (MEM).
// Ports: if_* fetch side, mem_* data side, port_* memory macro,
// pipe_stall to the pipeline, perf_* counters (ARB_PERF_CNT_EN).
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  pipe_stall,
  output logic                  port_en,
  output logic                  port_we,
  output logic [ADDR_WIDTH-1:0] port_addr,
  output logic [DATA_WIDTH-1:0] port_wdata,
  input  logic [DATA_WIDTH-1:0] port_rdata,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_conflict_cnt
);

  arb_state_t state, state_nxt;
  arb_gnt_t   gnt, gnt_nxt;
  logic [WAIT_CNT_W-1:0] cnt;
  logic we_q;
  logic if_served, mem_served;
  logic if_pend, mem_pend;
  logic load;
  logic last;

  assign if_ready  = (state == ST_RESP) && (gnt == GNT_IF);
  assign mem_ready = (state == ST_RESP) && (gnt == GNT_MEM);

  // A request counts as done from its ready cycle onwards, so the
  // RESP cycle of the last request is already the advance cycle.
  assign if_pend  = if_req  & ~(if_served  | if_ready);
  assign mem_pend = mem_req & ~(mem_served | mem_ready);
  assign pipe_stall = if_pend | mem_pend;

  assign last    = (cnt == '0);
  assign port_en = (state == ST_ACCESS);
  assign port_we = port_en & we_q & last;

  // Data side has priority: it belongs to the older instruction.
  assign gnt_nxt = mem_pend ? GNT_MEM : GNT_IF;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (if_pend | mem_pend) begin
          load      = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (last)
          state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (if_pend | mem_pend) begin
          load      = 1'b1;
          state_nxt = ST_ACCESS;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      gnt        <= GNT_IF;
      cnt        <= '0;
      we_q       <= 1'b0;
      port_addr  <= '0;
      port_wdata <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_served  <= 1'b0;
      mem_served <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        gnt       <= gnt_nxt;
        cnt       <= WAIT_CNT_W'(WAIT_STATES);
        we_q      <= mem_pend & mem_we;
        port_addr <= mem_pend ? mem_addr : if_addr;
        if (mem_pend)
          port_wdata <= mem_wdata;
      end else if (port_en && !last) begin
        cnt <= cnt - 1'b1;
      end
      if (port_en && last && !we_q) begin
        if (gnt == GNT_MEM)
          mem_rdata <= port_rdata;
        else
          if_rdata <= port_rdata;
      end
      if (!pipe_stall) begin
        if_served  <= 1'b0;
        mem_served <= 1'b0;
      end else begin
        if (if_ready)
          if_served <= 1'b1;
        if (mem_ready)
          mem_served <= 1'b1;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic conflict;
  assign conflict = ((state == ST_IDLE) || (state == ST_RESP))
                  & if_pend & mem_pend;

  arb_perf_counter u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pipe_stall),
    .count (perf_stall_cnt)
  );

  arb_perf_counter u_conflict_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (conflict),
    .count (perf_conflict_cnt)
  );
`else
  assign perf_stall_cnt    = '0;
  assign perf_conflict_cnt = '0;
`endif

  a_if_held: assert property (@(posedge clk) disable iff (reset)
    (state == ST_ACCESS && gnt == GNT_IF) |-> if_req);

  a_mem_held: assert property (@(posedge clk) disable iff (reset)
    (state == ST_ACCESS && gnt == GNT_MEM) |-> mem_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction model.
// Also checks reset abort and a zero-wait-state instance.
module tb_mem_port_arbiter;

  localparam int WS = 1;
  localparam int L  = WS + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        pipe_stall;
  logic        port_en;
  logic        port_we;
  logic [31:0] port_addr;
  logic [31:0] port_wdata;
  logic [31:0] port_rdata;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_conflict_cnt;

  logic        z_if_req = 1'b0;
  logic [31:0] z_if_addr = '0;
  logic [31:0] z_if_rdata;
  logic        z_if_ready;
  logic [31:0] z_mem_rdata;
  logic        z_mem_ready;
  logic        z_pipe_stall;
  logic        z_port_en;
  logic        z_port_we;
  logic [31:0] z_port_addr;
  logic [31:0] z_port_wdata;
  logic [31:0] z_stall_cnt;
  logic [31:0] z_conf_cnt;
  logic [31:0] z_port_rdata = 32'h2008000A;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WAIT_STATES(WS)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pipe_stall(pipe_stall),
    .port_en(port_en), .port_we(port_we),
    .port_addr(port_addr), .port_wdata(port_wdata),
    .port_rdata(port_rdata),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_conflict_cnt(perf_conflict_cnt)
  );

  mem_port_arbiter #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .if_req(z_if_req), .if_addr(z_if_addr),
    .if_rdata(z_if_rdata), .if_ready(z_if_ready),
    .mem_req(1'b0), .mem_we(1'b0),
    .mem_addr(32'h0), .mem_wdata(32'h0),
    .mem_rdata(z_mem_rdata), .mem_ready(z_mem_ready),
    .pipe_stall(z_pipe_stall),
    .port_en(z_port_en), .port_we(z_port_we),
    .port_addr(z_port_addr), .port_wdata(z_port_wdata),
    .port_rdata(z_port_rdata),
    .perf_stall_cnt(z_stall_cnt),
    .perf_conflict_cnt(z_conf_cnt)
  );

  // Memory macro stand-in: unwritten words read a fixed pattern.
  bit [31:0] tmem [0:1023];
  bit        tval [0:1023];

  function automatic logic [31:0] seed(input int idx);
    return (32'(idx) * 32'h9E3779B1) ^ 32'h2008000A;
  endfunction

  always @(posedge clk)
    if (port_en && port_we) begin
      tmem[port_addr[11:2]] <= port_wdata;
      tval[port_addr[11:2]] <= 1'b1;
    end

  assign port_rdata = tval[port_addr[11:2]] ?
                      tmem[port_addr[11:2]] :
                      seed(int'(port_addr[11:2]));

  // Reference state
  logic [31:0] ref_mem [0:1023];
  logic [31:0] last_mrd;
  int exp_stall;
  int exp_conf;
  int n_vec;
  int n_err;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic run_bundle(input bit di, input bit dm,
                            input bit we,
                            input logic [31:0] ia,
                            input logic [31:0] ma,
                            input logic [31:0] wd);
    int k, t_if, t_mem, n_we, stl;
    bit fin;
    logic [31:0] e_if, e_mem;
    int e_tif, e_tmem, e_stl;
    e_mem = last_mrd;
    e_if  = '0;
    if (dm) begin
      if (we)
        ref_mem[ma[11:2]] = wd;
      else
        e_mem = ref_mem[ma[11:2]];
      last_mrd = e_mem;
    end
    if (di)
      e_if = ref_mem[ia[11:2]];
    e_tmem = dm ? L : -1;
    e_tif  = di ? (dm ? 2 * L : L) : -1;
    e_stl  = (di && dm) ? 2 * L : L;
    exp_stall += e_stl;
    if (di && dm)
      exp_conf++;
    @(posedge clk);
    #1;
    if_req    = di;
    if_addr   = ia;
    mem_req   = dm;
    mem_we    = we;
    mem_addr  = ma;
    mem_wdata = wd;
    k = 0; t_if = -1; t_mem = -1;
    n_we = 0; stl = 0; fin = 0;
    while (!fin && k < 40) begin
      #1;
      if (pipe_stall) stl++;
      if (if_ready) begin
        t_if = k;
        chk("if_rdata", if_rdata, e_if);
      end
      if (mem_ready) begin
        t_mem = k;
        chk("mem_rdata", mem_rdata, e_mem);
      end
      if (port_we) begin
        n_we++;
        chk("we_addr", port_addr, ma);
        chk("we_data", port_wdata, wd);
      end
      if (!pipe_stall) begin
        fin = 1;
      end else begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    chk("advance", 32'(fin), 32'd1);
    chk("if_ready_cyc", 32'(t_if), 32'(e_tif));
    chk("mem_ready_cyc", 32'(t_mem), 32'(e_tmem));
    chk("stall_cycles", 32'(stl), 32'(e_stl));
    chk("we_pulses", 32'(n_we), 32'(dm && we));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if_req  = 1'b0;
      mem_req = 1'b0;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_stall = 0;
    exp_conf = 0;
    last_mrd = '0;
    for (int i = 0; i < 1024; i++)
      ref_mem[i] = seed(i);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_port_en", 32'(port_en), 32'd0);
    chk("rst_port_we", 32'(port_we), 32'd0);
    chk("rst_stall", 32'(pipe_stall), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_port_addr", port_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
    chk("rst_perf_conf", perf_conflict_cnt, 32'd0);

    // Zero wait states: single fetch
    @(posedge clk);
    #1 z_if_req = 1'b1;
    z_if_addr = 32'h40;
    #1 chk("ws0_en_c0", 32'(z_port_en), 32'd0);
    chk("ws0_stall_c0", 32'(z_pipe_stall), 32'd1);
    @(posedge clk);
    #2 chk("ws0_en_c1", 32'(z_port_en), 32'd1);
    chk("ws0_rdy_c1", 32'(z_if_ready), 32'd0);
    @(posedge clk);
    #2 chk("ws0_en_c2", 32'(z_port_en), 32'd0);
    chk("ws0_rdy_c2", 32'(z_if_ready), 32'd1);
    chk("ws0_rdata", z_if_rdata, 32'h2008000A);
    chk("ws0_stall_c2", 32'(z_pipe_stall), 32'd0);
    @(posedge clk);
    #1 z_if_req = 1'b0;

    // Reset in the final cycle of a store aborts it
    @(posedge clk);
    #1 mem_req = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h800;
    mem_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #2 chk("abort_en_c1", 32'(port_en), 32'd1);
    @(posedge clk);
    #2 chk("abort_we_c2", 32'(port_we), 32'd1);
    reset   = 1'b1;
    mem_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 3; c < 6; c++) begin
      #1;
      chk("abort_en", 32'(port_en), 32'd0);
      chk("abort_we", 32'(port_we), 32'd0);
      chk("abort_ready", 32'(mem_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("abort_perf_s", perf_stall_cnt, 32'd0);
    chk("abort_perf_c", perf_conflict_cnt, 32'd0);
    last_mrd = '0;

    // Directed: fetch, fetch+load conflict, store then load
    run_bundle(1, 0, 0, 32'h40, 32'h0, 32'h0);
    run_bundle(1, 1, 0, 32'h44, 32'h100, 32'h0);
    run_bundle(0, 1, 1, 32'h0, 32'h10, 32'hDEADBEEF);
    run_bundle(0, 1, 0, 32'h0, 32'h10, 32'h0);

    // Back-to-back fetches
    for (int i = 0; i < 10; i++)
      run_bundle(1, 0, 0, 32'(i * 4), 32'h0, 32'h0);

    for (int i = 0; i < 60; i++) begin
      int kind;
      bit di, dm, we;
      logic [31:0] ia, ma, wd;
      kind = $urandom_range(0, 3);
      di = (kind != 1);
      dm = (kind != 0);
      we = 1'($urandom_range(0, 1));
      ia = 32'($urandom_range(0, 15)) << 2;
      ma = 32'($urandom_range(0, 15)) << 2;
      wd = $urandom;
      run_bundle(di, dm, we, ia, ma, wd);
      idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(2);

`ifdef ARB_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, 32'(exp_stall));
    chk("perf_conf", perf_conflict_cnt, 32'(exp_conf));
`else
    chk("perf_stall", perf_stall_cnt, 32'd0);
    chk("perf_conf", perf_conflict_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
